// File: rtl/flash_pkg.sv
// -----------------------------------------------------------------------------
// flash_pkg
// Shared definitions for the NOR flash byte-program engine:
//   - state_t      : sequencer states of flash_writer
//   - CMD_*        : JEDEC command bytes written during a program sequence
//   - ADDR_*       : byte-mode unlock / reset addresses
//   - byte_of()    : picks byte b of a 32-bit sample, byte 0 = [31:24]
// -----------------------------------------------------------------------------
package flash_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,     // waiting for a request
    ST_ARM,      // first cycle of a request; launches the first unlock write
    ST_CMD,      // unlock / unlock / program / data write sequence
    ST_POLL,     // data# polling read in flight
    ST_GAP,      // OE# high for one cycle before the next poll read
    ST_VERIFY,   // full-byte read-back (optional build)
    ST_ERR,      // launches the read-mode reset write
    ST_RECOVER,  // read-mode reset write in flight
    ST_DONE      // completion pulse
  } state_t;

  localparam logic [7:0]  CMD_UNLOCK1  = 8'hAA;
  localparam logic [7:0]  CMD_UNLOCK2  = 8'h55;
  localparam logic [7:0]  CMD_PROG     = 8'hA0;
  localparam logic [7:0]  CMD_RESET    = 8'hF0;

  localparam logic [22:0] ADDR_UNLOCK1 = 23'h000AAA;
  localparam logic [22:0] ADDR_UNLOCK2 = 23'h000555;
  localparam logic [22:0] ADDR_RESET   = 23'h000000;

  function automatic logic [7:0] byte_of(input logic [31:0] d, input logic [1:0] b);
    case (b)
      2'd0:    return d[31:24];
      2'd1:    return d[23:16];
      2'd2:    return d[15:8];
      default: return d[7:0];
    endcase
  endfunction

endpackage

// File: rtl/flash_writer_if.sv
// -----------------------------------------------------------------------------
// flash_writer_if
// Request/response handshake between the sample-upload controller and
// flash_writer.
//   i_start    : one-cycle request (ignored while o_busy=1)
//   i_top_addr : page address, becomes flash address [22:2]
//   i_data     : 32-bit sample, [31:24] lands at byte offset 0
//   o_busy     : operation in progress
//   o_ack      : one-cycle completion pulse
//   o_err      : meaningful only with o_ack; 1 = timeout or DQ5 failure
// Modports: master = requester, slave = flash_writer.
// -----------------------------------------------------------------------------
interface flash_writer_if;
  logic        i_start;
  logic [20:0] i_top_addr;
  logic [31:0] i_data;
  logic        o_busy;
  logic        o_ack;
  logic        o_err;

  modport master (output i_start, output i_top_addr, output i_data,
                  input  o_busy,  input  o_ack,      input  o_err);

  modport slave  (input  i_start, input  i_top_addr, input  i_data,
                  output o_busy,  output o_ack,      output o_err);
endinterface

// File: rtl/flash_bus_cycle.sv
// -----------------------------------------------------------------------------
// flash_bus_cycle
// Generates one flash bus cycle per go pulse.
//   write (rd=0): SETUP_CYC cycles WE# high, PULSE_CYC cycles WE# low,
//                 HOLD_CYC cycles WE# high; DQ driven the whole time.
//   read  (rd=1): READ_CYC cycles OE# low, DQ released.
// Strobes are registered, so the cycle appears on the pins the clock after go.
// done is high in the last cycle of the bus cycle; rdata is the flash DQ and
// is the sampled value in that cycle. A go in the done cycle chains the next
// bus cycle with no idle clock in between.
// Ports: i_clk, i_rst (sync, active-high), go, rd, addr, wdata, i_data_in,
//        done, rdata, o_addr, o_data_out, o_data_oe, o_we_n, o_oe_n.
// -----------------------------------------------------------------------------
module flash_bus_cycle #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int HOLD_CYC  = 2,
  parameter int READ_CYC  = 6
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        go,
  input  logic        rd,
  input  logic [22:0] addr,
  input  logic [7:0]  wdata,
  input  logic [7:0]  i_data_in,
  output logic        done,
  output logic [7:0]  rdata,
  output logic [22:0] o_addr,
  output logic [7:0]  o_data_out,
  output logic        o_data_oe,
  output logic        o_we_n,
  output logic        o_oe_n
);

  localparam logic [7:0] WR_LAST  = 8'(SETUP_CYC + PULSE_CYC + HOLD_CYC - 1);
  localparam logic [7:0] RD_LAST  = 8'(READ_CYC - 1);
  localparam logic [7:0] PULSE_LO = 8'(SETUP_CYC);
  localparam logic [7:0] PULSE_HI = 8'(SETUP_CYC + PULSE_CYC);

  logic       active, rd_q;
  logic [7:0] cnt;
  logic       n_active, n_rd;
  logic [7:0] n_cnt;

  assign done  = active && (cnt == (rd_q ? RD_LAST : WR_LAST));
  assign rdata = i_data_in;

  always_comb begin
    n_active = active;
    n_rd     = rd_q;
    n_cnt    = cnt;
    if (go) begin
      n_active = 1'b1;
      n_rd     = rd;
      n_cnt    = 8'd0;
    end else if (done) begin
      n_active = 1'b0;
      n_cnt    = 8'd0;
    end else if (active) begin
      n_cnt    = cnt + 8'd1;
    end
  end

  // Strobes are computed from the next phase so they leave a flop cleanly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      active     <= 1'b0;
      rd_q       <= 1'b0;
      cnt        <= 8'd0;
      o_we_n     <= 1'b1;
      o_oe_n     <= 1'b1;
      o_data_oe  <= 1'b0;
      o_addr     <= 23'd0;
      o_data_out <= 8'd0;
    end else begin
      active    <= n_active;
      rd_q      <= n_rd;
      cnt       <= n_cnt;
      o_we_n    <= !(n_active && !n_rd && (n_cnt >= PULSE_LO) && (n_cnt < PULSE_HI));
      o_oe_n    <= !(n_active && n_rd);
      o_data_oe <= n_active && !n_rd;
      if (go) begin
        o_addr <= addr;
        if (!rd) o_data_out <= wdata;
      end
    end
  end

endmodule

// File: rtl/flash_writer.sv
// -----------------------------------------------------------------------------
// flash_writer
// Programs one 32-bit sample as four bytes into an 8M x 8 NOR flash (byte
// mode) at {i_top_addr, b}, b = 0..3. Each byte gets the JEDEC sequence
// AA@AAA, 55@555, A0@AAA, data@addr, then data# polling on DQ7. A DQ5 flag
// earns one confirming read; POLL_MAX failed polls is a timeout. Any failure
// writes F0@000 to return the flash to read mode before the error ack.
// Ports:
//   i_clk, i_rst (sync, active-high)
//   req        : flash_writer_if.slave (start/addr/data in, busy/ack/err out)
//   i_data_in  : DQ from the flash
//   o_data_out, o_data_oe, o_addr, o_we_n, o_oe_n : flash bus
//   o_ce_n, o_rst_n, o_wp_n : tied 0, 1, 1
// Build option: define FLASH_WRITER_VERIFY_EN to add a full-byte read-back
// after each DQ7 pass; a mismatch is reported as an error.
// -----------------------------------------------------------------------------
module flash_writer
  import flash_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int HOLD_CYC  = 2,
  parameter int READ_CYC  = 6,
  parameter int POLL_MAX  = 4095
) (
  input  logic        i_clk,
  input  logic        i_rst,
  flash_writer_if.slave req,
  input  logic [7:0]  i_data_in,
  output logic [7:0]  o_data_out,
  output logic        o_data_oe,
  output logic [22:0] o_addr,
  output logic        o_we_n,
  output logic        o_oe_n,
  output logic        o_ce_n,
  output logic        o_rst_n,
  output logic        o_wp_n
);

  localparam int PC_W = $clog2(POLL_MAX + 1);
  localparam logic [PC_W-1:0] POLL_LAST = PC_W'(POLL_MAX - 1);

  state_t          state, nstate;
  logic [20:0]     top_q;
  logic [31:0]     data_q;
  logic [1:0]      b_q, n_b;
  logic [1:0]      step_q, n_step;
  logic [PC_W-1:0] poll_q, n_poll;
  logic            dq5_q, n_dq5;
  logic            err_q, n_err;

  logic            go, go_rd;
  logic [22:0]     go_addr;
  logic [7:0]      go_wdata;
  logic            bus_done;
  logic [7:0]      bus_rdata;
  logic            pass, fail;

  logic [22:0]     byte_addr;
  logic [7:0]      cur_byte;

  assign byte_addr = {top_q, b_q};
  assign cur_byte  = byte_of(data_q, b_q);

  function automatic logic [22:0] cmd_addr(input logic [1:0] step, input logic [22:0] baddr);
    case (step)
      2'd0:    return ADDR_UNLOCK1;
      2'd1:    return ADDR_UNLOCK2;
      2'd2:    return ADDR_UNLOCK1;
      default: return baddr;
    endcase
  endfunction

  function automatic logic [7:0] cmd_data(input logic [1:0] step, input logic [7:0] bval);
    case (step)
      2'd0:    return CMD_UNLOCK1;
      2'd1:    return CMD_UNLOCK2;
      2'd2:    return CMD_PROG;
      default: return bval;
    endcase
  endfunction

  flash_bus_cycle #(
    .SETUP_CYC (SETUP_CYC),
    .PULSE_CYC (PULSE_CYC),
    .HOLD_CYC  (HOLD_CYC),
    .READ_CYC  (READ_CYC)
  ) u_bus (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .go         (go),
    .rd         (go_rd),
    .addr       (go_addr),
    .wdata      (go_wdata),
    .i_data_in  (i_data_in),
    .done       (bus_done),
    .rdata      (bus_rdata),
    .o_addr     (o_addr),
    .o_data_out (o_data_out),
    .o_data_oe  (o_data_oe),
    .o_we_n     (o_we_n),
    .o_oe_n     (o_oe_n)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      b_q    <= 2'd0;
      step_q <= 2'd0;
      poll_q <= '0;
      dq5_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= nstate;
      b_q    <= n_b;
      step_q <= n_step;
      poll_q <= n_poll;
      dq5_q  <= n_dq5;
      err_q  <= n_err;
    end
  end

  // Request payload is plain data: captured on accept, no reset needed.
  always_ff @(posedge i_clk) begin
    if (state == ST_IDLE && req.i_start) begin
      top_q  <= req.i_top_addr;
      data_q <= req.i_data;
    end
  end

  // Bus cycles are launched in the done cycle of the previous one so the
  // command sequence and the first poll read run back to back.
  always_comb begin
    nstate   = state;
    n_b      = b_q;
    n_step   = step_q;
    n_poll   = poll_q;
    n_dq5    = dq5_q;
    n_err    = err_q;
    go       = 1'b0;
    go_rd    = 1'b0;
    go_addr  = byte_addr;
    go_wdata = cur_byte;
    pass     = 1'b0;
    fail     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req.i_start) begin
          n_b    = 2'd0;
          n_step = 2'd0;
          n_err  = 1'b0;
          nstate = ST_ARM;
        end
      end

      ST_ARM: begin
        go       = 1'b1;
        go_addr  = ADDR_UNLOCK1;
        go_wdata = CMD_UNLOCK1;
        nstate   = ST_CMD;
      end

      ST_CMD: begin
        if (bus_done) begin
          go = 1'b1;
          if (step_q != 2'd3) begin
            n_step   = step_q + 2'd1;
            go_addr  = cmd_addr(step_q + 2'd1, byte_addr);
            go_wdata = cmd_data(step_q + 2'd1, cur_byte);
          end else begin
            go_rd  = 1'b1;
            n_poll = '0;
            n_dq5  = 1'b0;
            nstate = ST_POLL;
          end
        end
      end

      ST_GAP: begin
        go     = 1'b1;
        go_rd  = 1'b1;
        nstate = ST_POLL;
      end

      ST_POLL: begin
        if (bus_done) begin
          if (bus_rdata[7] == cur_byte[7]) begin
`ifdef FLASH_WRITER_VERIFY_EN
            go     = 1'b1;
            go_rd  = 1'b1;
            nstate = ST_VERIFY;
`else
            pass   = 1'b1;
`endif
          end else if (dq5_q) begin
            // DQ5 was already up and DQ7 still disagrees: real failure.
            fail = 1'b1;
          end else if (bus_rdata[5]) begin
            n_dq5  = 1'b1;
            nstate = ST_GAP;
          end else if (poll_q == POLL_LAST) begin
            fail = 1'b1;
          end else begin
            n_poll = poll_q + 1'b1;
            nstate = ST_GAP;
          end
        end
      end

      ST_VERIFY: begin
        if (bus_done) begin
          if (bus_rdata == cur_byte) pass = 1'b1;
          else                       fail = 1'b1;
        end
      end

      ST_ERR: begin
        go       = 1'b1;
        go_addr  = ADDR_RESET;
        go_wdata = CMD_RESET;
        nstate   = ST_RECOVER;
      end

      ST_RECOVER: begin
        if (bus_done) nstate = ST_DONE;
      end

      ST_DONE: begin
        nstate = ST_IDLE;
      end

      default: begin
        nstate = ST_IDLE;
      end
    endcase

    if (pass) begin
      if (b_q == 2'd3) begin
        nstate = ST_DONE;
      end else begin
        n_b      = b_q + 2'd1;
        n_step   = 2'd0;
        go       = 1'b1;
        go_rd    = 1'b0;
        go_addr  = ADDR_UNLOCK1;
        go_wdata = CMD_UNLOCK1;
        nstate   = ST_CMD;
      end
    end

    if (fail) begin
      n_err  = 1'b1;
      nstate = ST_ERR;
    end
  end

  assign req.o_busy = (state != ST_IDLE) && (state != ST_DONE);
  assign req.o_ack  = (state == ST_DONE);
  assign req.o_err  = (state == ST_DONE) && err_q;

  assign o_ce_n  = 1'b0;
  assign o_rst_n = 1'b1;
  assign o_wp_n  = 1'b1;

endmodule

// File: tb/tb_flash_writer.sv
// -----------------------------------------------------------------------------
// tb_flash_writer
// Directed bench for flash_writer with a behavioural NOR flash model that
// logs every WE# pulse (address, data, width) and answers poll reads
// according to a scenario mode:
//   0 = byte completes on the first poll
//   1 = byte 2 completes on the 11th poll
//   2 = never completes, DQ5 set
//   3 = never completes, DQ5 clear
// -----------------------------------------------------------------------------
module tb_flash_writer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_data_in;
  logic [7:0]  o_data_out;
  logic        o_data_oe;
  logic [22:0] o_addr;
  logic        o_we_n, o_oe_n, o_ce_n, o_rst_n, o_wp_n;

  flash_writer_if req ();

  flash_writer dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .req        (req),
    .i_data_in  (i_data_in),
    .o_data_out (o_data_out),
    .o_data_oe  (o_data_oe),
    .o_addr     (o_addr),
    .o_we_n     (o_we_n),
    .o_oe_n     (o_oe_n),
    .o_ce_n     (o_ce_n),
    .o_rst_n    (o_rst_n),
    .o_wp_n     (o_wp_n)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int c0       = 0;

  // ---------------- flash model ----------------
  int          mode      = 0;
  logic [7:0]  prog_data = 8'h00;
  logic [1:0]  prog_idx  = 2'd0;
  int          nread     = 0;
  int          rd_cnt [4];
  logic [22:0] log_addr [$];
  logic [7:0]  log_data [$];
  int          log_w    [$];
  logic        prev_we = 1'b1, prev_oe = 1'b1, last_was_a0 = 1'b0;
  int          wlow = 0;
  logic [22:0] cap_a = '0;
  logic [7:0]  cap_d = '0;

  always @(negedge i_clk) begin
    if (o_we_n === 1'b0) begin
      wlow  = wlow + 1;
      cap_a = o_addr;
      cap_d = o_data_out;
    end else if (prev_we === 1'b0) begin
      log_addr.push_back(cap_a);
      log_data.push_back(cap_d);
      log_w.push_back(wlow);
      if (last_was_a0) begin
        prog_data = cap_d;
        prog_idx  = cap_a[1:0];
        nread     = 0;
      end
      last_was_a0 = (cap_a == 23'h000AAA) && (cap_d == 8'hA0);
      wlow = 0;
    end
    if (o_oe_n === 1'b0 && prev_oe === 1'b1) begin
      nread = nread + 1;
      rd_cnt[prog_idx] = rd_cnt[prog_idx] + 1;
    end
    prev_we = o_we_n;
    prev_oe = o_oe_n;
  end

  always_comb begin
    i_data_in = 8'h00;
    if (o_oe_n === 1'b0) begin
      if (mode == 0 || (mode == 1 && (prog_idx != 2'd2 || nread > 10)))
        i_data_in = prog_data;
      else
        i_data_in = {~prog_data[7], 1'b0, (mode == 2), 5'b00000};
    end
  end

  // ---------------- expected sequence ----------------
  function automatic logic [22:0] exp_addr(input logic [20:0] top, input int k);
    case (k % 4)
      0, 2:    return 23'h000AAA;
      1:       return 23'h000555;
      default: return {top, 2'(k / 4)};
    endcase
  endfunction

  function automatic logic [7:0] exp_data(input logic [31:0] d, input int k);
    case (k % 4)
      0:       return 8'hAA;
      1:       return 8'h55;
      2:       return 8'hA0;
      default: return d[31 - 8 * (k / 4) -: 8];
    endcase
  endfunction

  task automatic reset_model(input int m);
    mode = m;
    log_addr.delete();
    log_data.delete();
    log_w.delete();
    for (int i = 0; i < 4; i++) rd_cnt[i] = 0;
    nread       = 0;
    last_was_a0 = 1'b0;
  endtask

  // Called at a negedge; returns just after the accepting clock edge.
  task automatic start_txn(input logic [20:0] top, input logic [31:0] d);
    req.i_start    = 1'b1;
    req.i_top_addr = top;
    req.i_data     = d;
    @(posedge i_clk);
    #1;
    c0 = cyc;
    req.i_start = 1'b0;
  endtask

  task automatic wait_ack(input int limit, output bit seen, output int lat,
                          output logic e, output int busy_drops);
    seen = 1'b0; lat = -1; e = 1'b0; busy_drops = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge i_clk);
      if (req.o_ack === 1'b1) begin
        seen = 1'b1;
        lat  = cyc - c0;
        e    = req.o_err;
      end else if (req.o_busy !== 1'b1) begin
        busy_drops++;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    n_checks++;
    if ({o_we_n, o_oe_n, o_data_oe} !== 3'b110) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 110", {o_we_n, o_oe_n, o_data_oe});
    end
    n_checks++;
    if (o_data_out !== 8'h00 || o_addr !== 23'h0) begin
      n_fail++; $display("FAIL reset_bus: data %h addr %h expected 00 000000", o_data_out, o_addr);
    end
    n_checks++;
    if ({req.o_busy, req.o_ack, req.o_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_status: got %b expected 000", {req.o_busy, req.o_ack, req.o_err});
    end
    n_checks++;
    if ({o_ce_n, o_rst_n, o_wp_n} !== 3'b011) begin
      n_fail++; $display("FAIL reset_ties: got %b expected 011", {o_ce_n, o_rst_n, o_wp_n});
    end
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_program();
    bit seen; int lat, drops; logic e;
    reset_model(0);
    start_txn(21'h000123, 32'hDEADBEEF);
    wait_ack(400, seen, lat, e, drops);
    n_checks++;
    if (!seen || lat != 137) begin
      n_fail++; $display("FAIL prog_latency: seen %0d latency %0d expected 137", seen, lat);
    end
    n_checks++;
    if (e !== 1'b0) begin n_fail++; $display("FAIL prog_err: got %b expected 0", e); end
    n_checks++;
    if (drops != 0) begin n_fail++; $display("FAIL prog_busy: %0d busy-low cycles expected 0", drops); end
    n_checks++;
    if (log_addr.size() != 16) begin
      n_fail++; $display("FAIL prog_wcount: got %0d writes expected 16", log_addr.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        n_checks++;
        if (log_addr[k] !== exp_addr(21'h000123, k) || log_data[k] !== exp_data(32'hDEADBEEF, k) || log_w[k] != 3) begin
          n_fail++;
          $display("FAIL prog_write%0d: got %h@%h w%0d expected %h@%h w3", k, log_data[k], log_addr[k],
                   log_w[k], exp_data(32'hDEADBEEF, k), exp_addr(21'h000123, k));
        end
      end
    end
  endtask

  task automatic test_poll_delay();
    bit seen; int lat, drops; logic e;
    @(negedge i_clk);
    reset_model(1);
    start_txn(21'h1FFFFF, 32'h1234807F);
    wait_ack(600, seen, lat, e, drops);
    n_checks++;
    if (!seen || lat != 207 || e !== 1'b0) begin
      n_fail++; $display("FAIL delay_ack: seen %0d latency %0d err %b expected 1 207 0", seen, lat, e);
    end
    n_checks++;
    if (rd_cnt[2] != 11 || rd_cnt[0] != 1) begin
      n_fail++; $display("FAIL delay_reads: byte2 %0d byte0 %0d expected 11 1", rd_cnt[2], rd_cnt[0]);
    end
    n_checks++;
    if (log_addr.size() != 16 || log_addr[15] !== 23'h7FFFFF || log_data[15] !== 8'h7F) begin
      n_fail++; $display("FAIL delay_last_write: count %0d got %h@%h expected 16 7f@7fffff",
                         log_addr.size(), log_data[log_data.size()-1], log_addr[log_addr.size()-1]);
    end
  endtask

  task automatic test_dq5_fail();
    bit seen; int lat, drops; logic e;
    @(negedge i_clk);
    reset_model(2);
    start_txn(21'h0ABCDE, 32'h00FF00FF);
    wait_ack(400, seen, lat, e, drops);
    n_checks++;
    if (!seen || e !== 1'b1) begin
      n_fail++; $display("FAIL dq5_ack: seen %0d err %b expected 1 1", seen, e);
    end
    n_checks++;
    if (rd_cnt[0] != 2) begin n_fail++; $display("FAIL dq5_reads: got %0d expected 2", rd_cnt[0]); end
    n_checks++;
    if (log_addr.size() != 5 || log_addr[4] !== 23'h0 || log_data[4] !== 8'hF0) begin
      n_fail++; $display("FAIL dq5_reset_write: count %0d got %h@%h expected 5 f0@000000",
                         log_addr.size(), log_data[log_data.size()-1], log_addr[log_addr.size()-1]);
    end
  endtask

  task automatic test_timeout();
    bit seen; int lat, drops; logic e;
    @(negedge i_clk);
    reset_model(3);
    start_txn(21'h000001, 32'h80000000);
    wait_ack(30000, seen, lat, e, drops);
    n_checks++;
    if (!seen || e !== 1'b1) begin
      n_fail++; $display("FAIL timeout_ack: seen %0d err %b expected 1 1", seen, e);
    end
    n_checks++;
    if (rd_cnt[0] != 4095) begin n_fail++; $display("FAIL timeout_reads: got %0d expected 4095", rd_cnt[0]); end
    n_checks++;
    if (log_addr.size() != 5 || log_addr[4] !== 23'h0 || log_data[4] !== 8'hF0) begin
      n_fail++; $display("FAIL timeout_reset_write: count %0d got %h@%h expected 5 f0@000000",
                         log_addr.size(), log_data[log_data.size()-1], log_addr[log_addr.size()-1]);
    end
  endtask

  task automatic test_reset_mid();
    bit found; int acks, busys;
    @(negedge i_clk);
    reset_model(0);
    start_txn(21'h000200, 32'h11223344);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge i_clk);
      if (log_addr.size() == 4 && o_we_n === 1'b0) found = 1'b1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL rstmid_reach: byte 1 pulse not seen, got 0 expected 1"); end
    i_rst = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if ({o_we_n, o_data_oe, req.o_busy, o_oe_n, req.o_ack} !== 5'b10010) begin
      n_fail++; $display("FAIL rstmid_release: we,doe,busy,oe,ack %b expected 10010",
                         {o_we_n, o_data_oe, req.o_busy, o_oe_n, req.o_ack});
    end
    i_rst = 1'b0;
    acks = 0; busys = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clk);
      if (req.o_ack !== 1'b0) acks++;
      if (req.o_busy !== 1'b0) busys++;
    end
    n_checks++;
    if (acks != 0 || busys != 0) begin
      n_fail++; $display("FAIL rstmid_quiet: acks %0d busy %0d expected 0 0", acks, busys);
    end
  endtask

  task automatic test_back_to_back();
    bit seen; int lat, drops; logic e;
    @(negedge i_clk);
    reset_model(0);
    start_txn(21'h000010, 32'h01020304);
    repeat (20) @(negedge i_clk);
    req.i_start    = 1'b1;
    req.i_top_addr = 21'h0ABCDE;
    req.i_data     = 32'hFFFFFFFF;
    @(negedge i_clk);
    req.i_start = 1'b0;
    wait_ack(400, seen, lat, e, drops);
    n_checks++;
    if (!seen || lat != 137 || e !== 1'b0 || drops != 0) begin
      n_fail++; $display("FAIL b2b_first: seen %0d latency %0d err %b drops %0d expected 1 137 0 0",
                         seen, lat, e, drops);
    end
    n_checks++;
    if (log_addr.size() != 16) begin
      n_fail++; $display("FAIL b2b_first_wcount: got %0d expected 16", log_addr.size());
    end else begin
      for (int k = 3; k < 16; k += 4) begin
        n_checks++;
        if (log_addr[k] !== exp_addr(21'h000010, k) || log_data[k] !== exp_data(32'h01020304, k)) begin
          n_fail++; $display("FAIL b2b_first_byte%0d: got %h@%h expected %h@%h", k / 4, log_data[k],
                             log_addr[k], exp_data(32'h01020304, k), exp_addr(21'h000010, k));
        end
      end
    end
    // Start in the cycle right after the ack.
    @(negedge i_clk);
    reset_model(0);
    start_txn(21'h155555, 32'hA5C33C5A);
    wait_ack(400, seen, lat, e, drops);
    n_checks++;
    if (!seen || lat != 137 || e !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second: seen %0d latency %0d err %b expected 1 137 0", seen, lat, e);
    end
    n_checks++;
    if (log_addr.size() != 16) begin
      n_fail++; $display("FAIL b2b_second_wcount: got %0d expected 16", log_addr.size());
    end else begin
      for (int k = 3; k < 16; k += 4) begin
        n_checks++;
        if (log_addr[k] !== exp_addr(21'h155555, k) || log_data[k] !== exp_data(32'hA5C33C5A, k)) begin
          n_fail++; $display("FAIL b2b_second_byte%0d: got %h@%h expected %h@%h", k / 4, log_data[k],
                             log_addr[k], exp_data(32'hA5C33C5A, k), exp_addr(21'h155555, k));
        end
      end
    end
  endtask

  initial begin
    req.i_start    = 1'b0;
    req.i_top_addr = '0;
    req.i_data     = '0;
    for (int i = 0; i < 4; i++) rd_cnt[i] = 0;
    test_reset();
    test_program();
    test_poll_delay();
    test_dq5_fail();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_writer.md
Name: flash_writer

Overview:
- Programs one 32-bit sample (4 bytes) into the 8M x 8 parallel NOR flash in byte mode, at the same page addresses the flash read path uses.
- Issues the JEDEC unlock/program command sequence per byte, then polls DQ7 (data# polling) until the byte completes.
- Sits beside the flash read engine on the shared flash pins; the top-level mux grants the bus to one engine at a time.
- Used by the sample-upload path: UART/USB into SDRAM, then flash.

Parameters:
- SETUP_CYC, 2, cycles address/data are stable with WE# high before the WE# low pulse.
- PULSE_CYC, 3, cycles WE# is held low.
- HOLD_CYC, 2, cycles address/data are held after WE# rises.
- READ_CYC, 6, cycles OE# is low per poll read; DQ is sampled on the last cycle.
- POLL_MAX, 4095, maximum poll reads per byte before a timeout error.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  one-cycle request; ignored while o_busy=1
- i_top_addr  in  21  page address; becomes o_addr[22:2]
- i_data  in  32  sample to program; [31:24] goes to byte offset 0, [7:0] to offset 3
- i_data_in  in  8  DQ[7:0] read from the flash
- o_data_out  out  8  DQ[7:0] driven to the flash
- o_data_oe  out  1  1 = the top level drives DQ with o_data_out
- o_addr  out  23  flash address
- o_we_n, o_oe_n  out  1 each  flash strobes
- o_ce_n, o_rst_n, o_wp_n  out  1 each  constants: 0, 1, 1
- o_busy  out  1  operation in progress
- o_ack  out  1  one-cycle completion pulse
- o_err  out  1  valid only while o_ack=1; 1 = timeout or DQ5 failure

Behaviour:
- Reset values: o_we_n=1, o_oe_n=1, o_data_oe=0, o_data_out=0, o_addr=0, o_busy=0, o_ack=0, o_err=0.
- Reset is honoured mid-operation: the bus is released the next cycle with no completion pulse.
- On accepting i_start, latch i_top_addr and i_data, set o_busy=1, and set byte index b=0.
- Bus write cycle W (W = SETUP_CYC + PULSE_CYC + HOLD_CYC cycles):
  - o_data_oe=1 and o_oe_n=1 for the whole cycle.
  - o_we_n=0 only during the PULSE window.
- States:
  - IDLE: wait for i_start.
  - CMD: four write cycles per byte:
    - (0xAAA, 0xAA)
    - (0x555, 0x55)
    - (0xAAA, 0xA0)
    - ({top, b}, byte_b)
  - POLL: o_data_oe=0, o_oe_n=0, o_addr={top, b} for READ_CYC cycles; sample on the last cycle.
    - DQ7 == byte_b[7]: go to NEXT.
    - DQ7 differs and DQ5=1: one extra read. If DQ7 still differs, go to ERR.
    - DQ7 differs and DQ5=0: increment the poll count. Go to ERR when the count reaches POLL_MAX; otherwise re-read.
    - o_oe_n goes high for 1 cycle between consecutive reads.
  - NEXT: b==3 goes to DONE; otherwise b++ and go to CMD.
  - DONE: o_ack=1, o_err=0.
  - ERR: issue write cycle (0x000, 0xF0) to return the flash to read mode, then o_ack=1, o_err=1.
  - After DONE or ERR: o_busy=0 in the ack cycle and return to IDLE. A new i_start is accepted the cycle after o_ack.
- Latency with defaults and first-read poll success: o_ack rises 4*(4*7+6)+1 = 137 cycles after the i_start edge.
- o_busy stays 1 from the cycle after i_start through the cycle before o_ack.

Optional Feature:
- Macro FLASH_WRITER_VERIFY_EN.
- Defined: after a DQ7 poll pass, perform one extra READ_CYC read of {top, b} and compare all 8 bits with byte_b. A mismatch goes to ERR. Default success latency becomes 161.
- Undefined: no verify read; the DQ7 pass alone completes the byte.

Decomposition:
- Package flash_pkg holds:
  - state enum
  - command constants: CMD_UNLOCK1=0xAA, CMD_UNLOCK2=0x55, CMD_PROG=0xA0, CMD_RESET=0xF0
  - address constants: ADDR_UNLOCK1=0xAAA, ADDR_UNLOCK2=0x555
- One sub-module, flash_bus_cycle:
  - takes a go pulse, a read/write select, address and data
  - generates the WE#/OE#/data_oe timing from the SETUP/PULSE/HOLD/READ parameters
  - returns done plus the sampled byte

Test Plan:
- Program top=0x000123, data=0xDEADBEEF; flash model passes on the first poll:
  - exactly 16 WE# pulses in order: AA@AAA, 55@555, A0@AAA, DE@0x00048C, ..., EF@0x00048F
  - o_ack at cycle 137 with o_err=0
- Model delays DQ7 by 10 polls on byte 2 -> 10 extra read cycles; o_ack with o_err=0.
- Model sets DQ5=1 with DQ7 never matching -> F0@0x000 written; o_ack with o_err=1.
- Model never completes and never sets DQ5 -> error after POLL_MAX reads; o_err=1.
- i_rst asserted during byte 1 PULSE -> next cycle o_we_n=1, o_data_oe=0, o_busy=0, and o_ack never pulses.
- i_start pulsed while busy -> ignored; the transaction and latched data are unchanged. i_start in the cycle after o_ack is accepted.
